// File: rtl/rr_mux4_arb_pkg.sv
// Shared types and pointer-scan helpers for the round-robin 4:1 arbiter.
// Burst locking is enabled by defining RR_MUX_BURST_EN.
package rr_mux_pkg;

   localparam int NCH = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {UNLOCKED, LOCKED} lock_t;

   // First valid channel at or after ptr, wrapping modulo NCH
   function automatic sel_t rr_pick(
      input sel_t ptr,
      input logic [NCH-1:0] valid
   );
      sel_t idx;
      rr_pick = ptr;
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = ptr + sel_t'(k);
         if (valid[idx]) rr_pick = idx;
      end
   endfunction

   function automatic logic [NCH-1:0] onehot(input sel_t s);
      logic [NCH-1:0] v;
      v = '0;
      v[s] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_mux4_arb_if.sv
// Four-channel request side plus registered output handshake.
// req_last/out_last exist only with RR_MUX_BURST_EN.
interface rr_mux4_arb_if #(
   parameter int width = 8
);
   logic [3:0]       req_valid;
   logic [3:0]       req_ready;
   logic [width-1:0] d0;
   logic [width-1:0] d1;
   logic [width-1:0] d2;
   logic [width-1:0] d3;
   logic             out_valid;
   logic             out_ready;
   logic [width-1:0] out_data;
   logic [1:0]       out_sel;
`ifdef RR_MUX_BURST_EN
   logic [3:0]       req_last;
   logic             out_last;

   modport slave (
      input  req_valid, d0, d1, d2, d3,
      input  out_ready, req_last,
      output req_ready, out_valid,
      output out_data, out_sel, out_last
   );

   modport master (
      output req_valid, d0, d1, d2, d3,
      output out_ready, req_last,
      input  req_ready, out_valid,
      input  out_data, out_sel, out_last
   );
`else
   modport slave (
      input  req_valid, d0, d1, d2, d3,
      input  out_ready,
      output req_ready, out_valid,
      output out_data, out_sel
   );

   modport master (
      output req_valid, d0, d1, d2, d3,
      output out_ready,
      input  req_ready, out_valid,
      input  out_data, out_sel
   );
`endif
endinterface

// File: rtl/rr_mux4_arb_mux4w.sv
// Parameterized 4:1 datapath mux composed of three 2:1 stages.
module mux2 #(
   parameter int width = 8
) (
   input  logic             s,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic [width-1:0] y
);
   assign y = s ? b : a;
endmodule

module mux4w
   import rr_mux_pkg::*;
#(
   parameter int width = 8
) (
   input  sel_t             sel,
   input  logic [width-1:0] a0,
   input  logic [width-1:0] a1,
   input  logic [width-1:0] a2,
   input  logic [width-1:0] a3,
   output logic [width-1:0] y
);
   logic [width-1:0] lo;
   logic [width-1:0] hi;

   mux2 #(.width(width)) u_lo (
      .s(sel[0]), .a(a0), .b(a1), .y(lo)
   );

   mux2 #(.width(width)) u_hi (
      .s(sel[0]), .a(a2), .b(a3), .y(hi)
   );

   mux2 #(.width(width)) u_out (
      .s(sel[1]), .a(lo), .b(hi), .y(y)
   );
endmodule

// File: rtl/rr_mux4_arb.sv
// Round-robin 4-channel arbiter with one-entry registered output.
// Define RR_MUX_BURST_EN to lock onto a channel until req_last.
module rr_mux4_arb
   import rr_mux_pkg::*;
#(
   parameter int width = 8
) (
   input logic          clk,
   input logic          reset_n,
   rr_mux4_arb_if.slave bus
);
   sel_t             ptr;
   sel_t             g;
   logic [NCH-1:0]   cand;
   logic             load;
   logic             vld_q;
   logic [width-1:0] data_q;
   sel_t             sel_q;
   logic [width-1:0] mux_y;

`ifdef RR_MUX_BURST_EN
   lock_t state;
   sel_t  lock_ch;
   logic  last_q;

   always_comb begin
      cand = bus.req_valid;
      if (state == LOCKED)
         cand = bus.req_valid & onehot(lock_ch);
   end
`else
   always_comb cand = bus.req_valid;
`endif

   always_comb begin
      g    = rr_pick(ptr, cand);
      load = (!vld_q || bus.out_ready) && |cand;
   end

   // Held low during reset even though channels may be valid
   always_comb begin
      bus.req_ready = '0;
      if (reset_n && load)
         bus.req_ready = onehot(g);
   end

   mux4w #(.width(width)) u_mux (
      .sel(g),
      .a0 (bus.d0),
      .a1 (bus.d1),
      .a2 (bus.d2),
      .a3 (bus.d3),
      .y  (mux_y)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr    <= '0;
         vld_q  <= 1'b0;
         data_q <= '0;
         sel_q  <= '0;
      end else if (load) begin
         ptr    <= g + 2'd1;
         vld_q  <= 1'b1;
         data_q <= mux_y;
         sel_q  <= g;
      end else if (bus.out_ready) begin
         vld_q  <= 1'b0;
      end
   end

`ifdef RR_MUX_BURST_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= UNLOCKED;
         lock_ch <= '0;
         last_q  <= 1'b0;
      end else if (load) begin
         last_q <= bus.req_last[g];
         unique case (state)
            UNLOCKED:
               if (!bus.req_last[g]) begin
                  state   <= LOCKED;
                  lock_ch <= g;
               end
            LOCKED:
               if (bus.req_last[g])
                  state <= UNLOCKED;
            default: state <= UNLOCKED;
         endcase
      end
   end

   assign bus.out_last = last_q;
`endif

   assign bus.out_valid = vld_q;
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;

endmodule
